// File: rtl/collision_detector.sv
// collision_detector: sequential scan of the obstacle slots against an inset
// T-rex bounding box. One slot is evaluated per cycle after a check pulse; the
// first overlapping active slot latches a sticky crash and its index.
module collision_detector #(
   parameter int MAX_OBSTACLES = 7,
   parameter int BOX_INSET     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          check,
   input  logic                          clear,
   input  logic signed [10:0]            trex_x_pos,
   input  logic [9:0]                    trex_y_pos,
   input  logic [9:0]                    trex_width,
   input  logic [9:0]                    trex_height,
   input  logic [MAX_OBSTACLES-1:0]      obstacle_start,
   input  logic [MAX_OBSTACLES*11-1:0]   obstacle_x_pos,
   input  logic [MAX_OBSTACLES*10-1:0]   obstacle_y_pos,
   input  logic [MAX_OBSTACLES*10-1:0]   obstacle_width,
   input  logic [MAX_OBSTACLES*10-1:0]   obstacle_height,
   output logic                          busy,
   output logic                          done,
   output logic                          crash,
   output logic [2:0]                    hit_index
);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE, ST_CRASHED} state_t;

   localparam logic signed [12:0] INSET13  = 13'(BOX_INSET);
   localparam logic [9:0]         INSET2   = 10'(2 * BOX_INSET);
   localparam logic [2:0]         LAST_IDX = 3'(MAX_OBSTACLES - 1);

   state_t             state_reg, state_next;
   logic [2:0]         idx_reg, idx_next;
   logic               crash_reg, crash_next;
   logic [2:0]         hit_index_reg, hit_index_next;
   logic signed [12:0] bx_reg, bx_next;
   logic signed [12:0] by_reg, by_next;
   logic [9:0]         bw_reg, bw_next;
   logic [9:0]         bh_reg, bh_next;

   // Per-slot operands widened to the common 13-bit signed arithmetic width:
   // x is sign-extended (obstacles may hang off the left edge), the rest are
   // zero-extended.
   logic signed [12:0] slot_x [MAX_OBSTACLES];
   logic signed [12:0] slot_y [MAX_OBSTACLES];
   logic signed [12:0] slot_w [MAX_OBSTACLES];
   logic signed [12:0] slot_h [MAX_OBSTACLES];

   genvar gi;
   generate
      for (gi = 0; gi < MAX_OBSTACLES; gi++) begin : g_slot
         assign slot_x[gi] = {{2{obstacle_x_pos[gi*11+10]}}, obstacle_x_pos[gi*11 +: 11]};
         assign slot_y[gi] = {3'b000, obstacle_y_pos[gi*10 +: 10]};
         assign slot_w[gi] = {3'b000, obstacle_width[gi*10 +: 10]};
         assign slot_h[gi] = {3'b000, obstacle_height[gi*10 +: 10]};
      end
   endgenerate

   logic signed [12:0] cur_x, cur_y, cur_w, cur_h;
   logic               cur_start;
   logic signed [12:0] bw_ext, bh_ext;
   logic signed [12:0] trex_x_ext, trex_y_ext;
   logic               slot_hit;

   assign cur_x     = slot_x[idx_reg];
   assign cur_y     = slot_y[idx_reg];
   assign cur_w     = slot_w[idx_reg];
   assign cur_h     = slot_h[idx_reg];
   assign cur_start = obstacle_start[idx_reg];

   assign bw_ext     = {3'b000, bw_reg};
   assign bh_ext     = {3'b000, bh_reg};
   assign trex_x_ext = {{2{trex_x_pos[10]}}, trex_x_pos};
   assign trex_y_ext = {3'b000, trex_y_pos};

   // Strict overlap: boxes that merely share an edge do not collide.
   assign slot_hit = cur_start
                     && (cur_w != 13'sd0) && (cur_h != 13'sd0)
                     && (bw_reg != 10'd0) && (bh_reg != 10'd0)
                     && (bx_reg < cur_x + cur_w) && (cur_x < bx_reg + bw_ext)
                     && (by_reg < cur_y + cur_h) && (cur_y < by_reg + bh_ext);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= 3'd0;
         crash_reg     <= 1'b0;
         hit_index_reg <= 3'd0;
         bx_reg        <= '0;
         by_reg        <= '0;
         bw_reg        <= '0;
         bh_reg        <= '0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         crash_reg     <= crash_next;
         hit_index_reg <= hit_index_next;
         bx_reg        <= bx_next;
         by_reg        <= by_next;
         bw_reg        <= bw_next;
         bh_reg        <= bh_next;
      end
   end

   // Next-state logic: snapshot box on check, walk slots, abort on first hit;
   // clear overrides everything else.
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      crash_next     = crash_reg;
      hit_index_next = hit_index_reg;
      bx_next        = bx_reg;
      by_next        = by_reg;
      bw_next        = bw_reg;
      bh_next        = bh_reg;

      case (state_reg)
         ST_IDLE: begin
            if (check) begin
               bx_next    = trex_x_ext + INSET13;
               by_next    = trex_y_ext + INSET13;
               bw_next    = (trex_width  > INSET2) ? (trex_width  - INSET2) : 10'd0;
               bh_next    = (trex_height > INSET2) ? (trex_height - INSET2) : 10'd0;
               idx_next   = 3'd0;
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (slot_hit) begin
               crash_next     = 1'b1;
               hit_index_next = idx_reg;
               state_next     = ST_DONE;
            end else if (idx_reg == LAST_IDX) begin
               state_next = ST_DONE;
            end else begin
               idx_next = idx_reg + 3'd1;
            end
         end
         ST_DONE: begin
            state_next = crash_reg ? ST_CRASHED : ST_IDLE;
         end
         default: begin
            state_next = ST_CRASHED;
         end
      endcase

      if (clear) begin
         crash_next     = 1'b0;
         hit_index_next = 3'd0;
         idx_next       = 3'd0;
         state_next     = ST_IDLE;
      end
   end

   assign busy      = (state_reg == ST_SCAN);
   assign done      = (state_reg == ST_DONE);
   assign crash     = crash_reg;
   assign hit_index = hit_index_reg;

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed and random scans compared against an
// interval-overlap reference model, plus clear/reset control events.
module tb_collision_detector;

   localparam int N     = 7;
   localparam int INSET = 4;

   logic                clk;
   logic                rst;
   logic                check;
   logic                clear;
   logic signed [10:0]  trex_x_pos;
   logic [9:0]          trex_y_pos;
   logic [9:0]          trex_width;
   logic [9:0]          trex_height;
   logic [N-1:0]        obstacle_start;
   logic [N*11-1:0]     obstacle_x_pos;
   logic [N*10-1:0]     obstacle_y_pos;
   logic [N*10-1:0]     obstacle_width;
   logic [N*10-1:0]     obstacle_height;
   logic                busy;
   logic                done;
   logic                crash;
   logic [2:0]          hit_index;

   logic                o_start [N];
   logic signed [10:0]  o_x [N];
   logic [9:0]          o_y [N];
   logic [9:0]          o_w [N];
   logic [9:0]          o_h [N];

   int n_checks = 0;
   int n_errors = 0;

   collision_detector #(.MAX_OBSTACLES(N), .BOX_INSET(INSET)) dut (
      .clk             (clk),
      .rst             (rst),
      .check           (check),
      .clear           (clear),
      .trex_x_pos      (trex_x_pos),
      .trex_y_pos      (trex_y_pos),
      .trex_width      (trex_width),
      .trex_height     (trex_height),
      .obstacle_start  (obstacle_start),
      .obstacle_x_pos  (obstacle_x_pos),
      .obstacle_y_pos  (obstacle_y_pos),
      .obstacle_width  (obstacle_width),
      .obstacle_height (obstacle_height),
      .busy            (busy),
      .done            (done),
      .crash           (crash),
      .hit_index       (hit_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack the per-slot arrays onto the flat obstacle buses.
   always_comb begin
      obstacle_start  = '0;
      obstacle_x_pos  = '0;
      obstacle_y_pos  = '0;
      obstacle_width  = '0;
      obstacle_height = '0;
      for (int i = 0; i < N; i++) begin
         obstacle_start[i]            = o_start[i];
         obstacle_x_pos[i*11 +: 11]   = o_x[i];
         obstacle_y_pos[i*10 +: 10]   = o_y[i];
         obstacle_width[i*10 +: 10]   = o_w[i];
         obstacle_height[i*10 +: 10]  = o_h[i];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Reference: first active slot whose rectangle shares a positive-area
   // intersection with the inset T-rex rectangle; -1 when none.
   function automatic int model_first_hit();
      int bx, by, bw, bh, ox, oy, ow, oh, ix, iy;
      bx = int'(trex_x_pos) + INSET;
      by = int'(trex_y_pos) + INSET;
      bw = imax(int'(trex_width)  - 2*INSET, 0);
      bh = imax(int'(trex_height) - 2*INSET, 0);
      for (int i = 0; i < N; i++) begin
         if (o_start[i]) begin
            ox = int'(o_x[i]);
            oy = int'(o_y[i]);
            ow = int'(o_w[i]);
            oh = int'(o_h[i]);
            ix = imin(bx + bw, ox + ow) - imax(bx, ox);
            iy = imin(by + bh, oy + oh) - imax(by, oy);
            if (ix > 0 && iy > 0 && bw > 0 && bh > 0) return i;
         end
      end
      return -1;
   endfunction

   task automatic set_trex(input int x, input int y, input int w, input int h);
      trex_x_pos  = 11'(x);
      trex_y_pos  = 10'(y);
      trex_width  = 10'(w);
      trex_height = 10'(h);
   endtask

   task automatic clear_slots();
      for (int i = 0; i < N; i++) begin
         o_start[i] = 1'b0;
         o_x[i] = '0; o_y[i] = '0; o_w[i] = '0; o_h[i] = '0;
      end
   endtask

   task automatic set_slot(input int i, input bit st, input int x, input int y, input int w, input int h);
      o_start[i] = st;
      o_x[i] = 11'(x);
      o_y[i] = 10'(y);
      o_w[i] = 10'(w);
      o_h[i] = 10'(h);
   endtask

   // Issue check in cycle 0 and verify busy/done/crash/hit_index each cycle.
   // recheck_at (>0) re-pulses check during the scan, which must be ignored.
   task automatic run_scan(input string tag, input bit scramble, input int recheck_at, output int eh);
      int dc;
      eh = model_first_hit();
      dc = (eh >= 0) ? eh + 2 : N + 1;
      $display("scan %s: expected hit=%0d done_cycle=%0d", tag, eh, dc);
      @(posedge clk); #1 check = 1'b1;
      @(posedge clk); #1 check = 1'b0;
      if (scramble)
         set_trex($urandom_range(0, 400) - 100, $urandom_range(0, 300),
                  $urandom_range(0, 80), $urandom_range(0, 80));
      for (int c = 1; c <= N + 3; c++) begin
         check = (c == recheck_at);
         @(negedge clk);
         check_eq({tag, "_busy"},  busy,  (c < dc) ? 1 : 0);
         check_eq({tag, "_done"},  done,  (c == dc) ? 1 : 0);
         check_eq({tag, "_crash"}, crash, (eh >= 0 && c >= dc) ? 1 : 0);
         if (eh >= 0 && c >= dc) check_eq({tag, "_hit_index"}, hit_index, eh);
         @(posedge clk); #1;
      end
      check = 1'b0;
   endtask

   task automatic do_clear(input string tag);
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      check_eq({tag, "_crash"},     crash,     0);
      check_eq({tag, "_hit_index"}, hit_index, 0);
      check_eq({tag, "_busy"},      busy,      0);
      check_eq({tag, "_done"},      done,      0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles, input bit exp_crash);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         check_eq({tag, "_busy"},  busy,  0);
         check_eq({tag, "_done"},  done,  0);
         check_eq({tag, "_crash"}, crash, exp_crash);
      end
   endtask

   task automatic set_common();
      set_trex(50, 93, 44, 47);
      clear_slots();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int eh;
      rst = 1'b0; check = 1'b0; clear = 1'b0;
      set_common();
      repeat (2) @(negedge clk);
      check_eq("reset_busy",      busy,      0);
      check_eq("reset_done",      done,      0);
      check_eq("reset_crash",     crash,     0);
      check_eq("reset_hit_index", hit_index, 0);
      rst = 1'b1;

      // All slots inactive.
      set_common();
      run_scan("empty", 1'b0, 0, eh);

      // Slot 3 hit, then check ignored while crashed, then clear.
      set_common();
      set_slot(3, 1, 80, 100, 17, 35);
      run_scan("slot3", 1'b0, 0, eh);
      @(posedge clk); #1 check = 1'b1;
      @(posedge clk); #1 check = 1'b0;
      expect_quiet("crashed_check", 6, 1'b1);
      check_eq("crashed_hold_index", hit_index, 3);
      do_clear("clear_after_hit");

      // Edge contact and negative x: no hit.
      set_common();
      set_slot(0, 1, 90, 100, 17, 35);
      set_slot(1, 1, -10, 100, 17, 35);
      run_scan("edges", 1'b0, 0, eh);

      // Inactive overlapping slot 5 is skipped; slot 6 hits.
      set_common();
      set_slot(5, 0, 60, 100, 17, 35);
      set_slot(6, 1, 60, 100, 17, 35);
      run_scan("slot6", 1'b0, 0, eh);
      do_clear("clear6");

      // Two overlapping slots: first one wins.
      set_common();
      set_slot(2, 1, 60, 100, 17, 35);
      set_slot(4, 1, 70, 110, 10, 10);
      run_scan("slot2", 1'b0, 0, eh);
      do_clear("clear2");

      // Check re-pulsed mid-scan and during DONE is not queued.
      set_common();
      run_scan("recheck_busy", 1'b0, 3, eh);
      run_scan("recheck_done", 1'b0, N + 1, eh);

      // Clear in cycle 3 aborts the scan without a done pulse.
      set_common();
      @(posedge clk); #1 check = 1'b1;
      @(posedge clk); #1 check = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 clear = 1'b1;
      @(negedge clk);
      check_eq("abort_busy_c3", busy, 1);
      @(posedge clk); #1 clear = 1'b0;
      expect_quiet("abort", 8, 1'b0);

      // Reset mid-scan clears outputs without a clock edge.
      @(posedge clk); #1 check = 1'b1;
      @(posedge clk); #1 check = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      #1;
      check_eq("rst_scan_busy", busy, 0);
      check_eq("rst_scan_done", done, 0);
      @(negedge clk) rst = 1'b1;
      expect_quiet("after_rst_scan", 9, 1'b0);

      // Reset while crashed.
      set_slot(3, 1, 80, 100, 17, 35);
      run_scan("pre_rst_hit", 1'b0, 0, eh);
      @(posedge clk); #2 rst = 1'b0;
      #1;
      check_eq("rst_crash",     crash,     0);
      check_eq("rst_hit_index", hit_index, 0);
      @(negedge clk) rst = 1'b1;

      // Simultaneous check and clear: stays idle.
      @(posedge clk); #1 check = 1'b1; clear = 1'b1;
      @(posedge clk); #1 check = 1'b0; clear = 1'b0;
      expect_quiet("check_clear", 9, 1'b0);

      // Random scenes, T-rex inputs changed mid-scan.
      for (int t = 0; t < 40; t++) begin
         set_trex($urandom_range(0, 120) - 20, $urandom_range(40, 160),
                  $urandom_range(0, 60), $urandom_range(0, 60));
         for (int i = 0; i < N; i++)
            set_slot(i, $urandom_range(0, 1), $urandom_range(0, 220) - 60,
                     $urandom_range(0, 220), $urandom_range(0, 40), $urandom_range(0, 40));
         run_scan($sformatf("rand%0d", t), 1'b1, $urandom_range(0, 4), eh);
         if (eh >= 0) do_clear($sformatf("rand%0d_clr", t));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
